// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_pkg
// Brief    : Shared types and constants for the program-counter fetch front
//            end: redirect kind encodings, fetch state encoding and the
//            default reset address.
// Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

    // Redirect kind encodings carried on redirectKind
    localparam logic [1:0] KIND_JUMP   = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_CALL   = 2'b10;
    localparam logic [1:0] KIND_RETURN = 2'b11;

    // Default PC value loaded on reset
    localparam logic [7:0] PC_DEFAULT_RESET_ADDR = 8'h00;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } fetch_state_t;

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_return_stack
// Brief    : LIFO of STACK_DEPTH return addresses with push/pop, full/empty
//            status and a combinational top-of-stack output. Asynchronous
//            reset empties the stack. Push on full and pop on empty are
//            ignored; the caller decides how to flag them.
// Revision : 1.0 - initial release
// ============================================================================
module pc_return_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int            PTR_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W:0] C_DEPTH    = (PTR_W + 1)'(STACK_DEPTH);
    localparam logic [PTR_W:0] C_CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] C_IDX_ONE = PTR_W'(1);

    // Occupancy count; one extra bit so that "full" is distinguishable from "empty"
    logic [PTR_W:0]      r_count;
    logic [ADDR_W-1:0]   r_entries [STACK_DEPTH];
    logic [PTR_W-1:0]    w_wr_idx;
    logic [PTR_W-1:0]    w_top_idx;
    logic                w_do_push;
    logic                w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty && !push;

    // Depth is a power of two, so the low count bits wrap naturally when full
    assign w_wr_idx  = r_count[PTR_W-1:0];
    assign w_top_idx = r_count[PTR_W-1:0] - C_IDX_ONE;

    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);
    assign top   = r_entries[w_top_idx];

    // Occupancy count: push has priority, reset empties the stack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + C_CNT_ONE;
        end else if (w_do_pop) begin
            r_count <= r_count - C_CNT_ONE;
        end
    end

    // Entry storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_entries[w_wr_idx] <= push_data;
        end
    end

endmodule : pc_return_stack
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter and instruction-fetch front end. Sequences
//            IDLE -> FETCH -> HOLD, holds each fetched byte until the decoder
//            accepts it and applies jump/branch/call/return redirects on the
//            accept cycle.
// Config   : PC_RETURN_STACK_EN - when defined, call pushes a return address
//            onto a hardware return stack and return pops it, with stackErr
//            flagging overflow/underflow. When undefined, call acts as jump,
//            return acts as no redirect and stackErr is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(PC_DEFAULT_RESET_ADDR),
    parameter int                STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memReq,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memData,
    output logic [DATA_W-1:0] instr,
    output logic              instrValid,
    input  logic              instrReady,
    output logic [ADDR_W-1:0] pcOut,
    input  logic              redirect,
    input  logic [1:0]        redirectKind,
    input  logic [ADDR_W-1:0] redirectOperand,
    output logic              stackErr
);

    localparam logic [ADDR_W-1:0] C_PC_ONE = ADDR_W'(1);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_pc_out;
    logic [DATA_W-1:0]  r_instr;
    logic               r_instr_valid;
    logic               r_mem_req;

    logic               w_accept;
    logic               w_take;
    logic [ADDR_W-1:0]  w_return_addr;
    logic [ADDR_W-1:0]  w_next_pc;

    // Accept happens only while holding an instruction; redirects count only then
    assign w_accept      = (r_state == HOLD) && instrReady;
    assign w_take        = w_accept && redirect;
    assign w_return_addr = r_pc_out + C_PC_ONE;

    // All outputs come straight from registers
    assign memAddr    = r_pc;
    assign memReq     = r_mem_req;
    assign instr      = r_instr;
    assign instrValid = r_instr_valid;
    assign pcOut      = r_pc_out;

`ifdef PC_RETURN_STACK_EN
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ADDR_W-1:0]  w_top;
    logic               w_err_set;
    logic               r_stack_err;

    assign w_push = w_take && (redirectKind == KIND_CALL)   && !w_full;
    assign w_pop  = w_take && (redirectKind == KIND_RETURN) && !w_empty;

    pc_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_return_addr),
        .top       (w_top),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Next PC on accept: sequential unless a redirect is taken
    always_comb begin
        w_next_pc = r_pc;
        w_err_set = 1'b0;
        if (w_take) begin
            case (redirectKind)
                KIND_JUMP:   w_next_pc = redirectOperand;
                KIND_BRANCH: w_next_pc = w_return_addr + redirectOperand;
                KIND_CALL: begin
                    // The jump is still taken when the push is dropped
                    w_next_pc = redirectOperand;
                    w_err_set = w_full;
                end
                KIND_RETURN: begin
                    if (w_empty) begin
                        w_next_pc = RESET_ADDR;
                        w_err_set = 1'b1;
                    end else begin
                        w_next_pc = w_top;
                    end
                end
                default: w_next_pc = r_pc;
            endcase
        end
    end

    // Sticky stack error: set on overflow/underflow, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stack_err <= 1'b0;
        end else if (w_err_set) begin
            r_stack_err <= 1'b1;
        end
    end

    assign stackErr = r_stack_err;
`else
    logic w_unused_stack_cfg;

    // No return stack is built, so its depth has no effect
    assign w_unused_stack_cfg = (STACK_DEPTH == 0);

    // Next PC on accept: call degrades to jump, return keeps the sequential PC
    always_comb begin
        w_next_pc = r_pc;
        if (w_take) begin
            case (redirectKind)
                KIND_JUMP:   w_next_pc = redirectOperand;
                KIND_BRANCH: w_next_pc = w_return_addr + redirectOperand;
                KIND_CALL:   w_next_pc = redirectOperand;
                KIND_RETURN: w_next_pc = r_pc;
                default:     w_next_pc = r_pc;
            endcase
        end
    end

    assign stackErr = 1'b0;
`endif

    // Fetch sequencer with registered memory request and instruction hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_ADDR;
            r_pc_out      <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_mem_req     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state   <= FETCH;
                    r_mem_req <= 1'b1;
                end
                FETCH: begin
                    if (memReady) begin
                        r_instr       <= memData;
                        r_pc_out      <= r_pc;
                        r_pc          <= r_pc + C_PC_ONE;
                        r_instr_valid <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_mem_req     <= 1'b1;
                        r_state       <= FETCH;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_instr_valid <= 1'b0;
                    r_mem_req     <= 1'b0;
                end
            endcase
        end
    end

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Self-checking bench for pc_fetch_unit with a transaction-level
//            reference model (expected PC, return-address queue, error flag).
//            Follows PC_RETURN_STACK_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int             AW       = 8;
    localparam int             DW       = 8;
    localparam int             DEPTH    = 4;
    localparam logic [AW-1:0]  RST_ADDR = 8'h00;
`ifdef PC_RETURN_STACK_EN
    localparam bit HAS_STACK = 1'b1;
`else
    localparam bit HAS_STACK = 1'b0;
`endif
    localparam logic [1:0] K_JUMP   = 2'd0;
    localparam logic [1:0] K_BRANCH = 2'd1;
    localparam logic [1:0] K_CALL   = 2'd2;
    localparam logic [1:0] K_RET    = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] memAddr;
    logic          memReq;
    logic          memReady;
    logic [DW-1:0] memData;
    logic [DW-1:0] instr;
    logic          instrValid;
    logic          instrReady;
    logic [AW-1:0] pcOut;
    logic          redirect;
    logic [1:0]    redirectKind;
    logic [AW-1:0] redirectOperand;
    logic          stackErr;

    pc_fetch_unit #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .RESET_ADDR  (RST_ADDR),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .memAddr         (memAddr),
        .memReq          (memReq),
        .memReady        (memReady),
        .memData         (memData),
        .instr           (instr),
        .instrValid      (instrValid),
        .instrReady      (instrReady),
        .pcOut           (pcOut),
        .redirect        (redirect),
        .redirectKind    (redirectKind),
        .redirectOperand (redirectOperand),
        .stackErr        (stackErr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_held_pc;
    logic [DW-1:0] m_held_instr;
    logic [AW-1:0] m_stack [$];
    logic          m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc         = RST_ADDR;
        m_held_pc    = '0;
        m_held_instr = '0;
        m_stack.delete();
        m_err        = 1'b0;
    endtask

    // Architectural effect of an accepted instruction, from the ISA rules
    task automatic model_accept(input bit redir, input logic [1:0] kind, input logic [AW-1:0] op);
        int t;
        m_pc = m_held_pc + 8'd1;
        if (redir) begin
            case (kind)
                K_JUMP: m_pc = op;
                K_BRANCH: begin
                    t    = int'(m_held_pc) + 1 + int'($signed(op));
                    m_pc = 8'((t + 512) % 256);
                end
                K_CALL: begin
                    if (HAS_STACK) begin
                        if (m_stack.size() < DEPTH) m_stack.push_back(m_held_pc + 8'd1);
                        else m_err = 1'b1;
                    end
                    m_pc = op;
                end
                default: begin
                    if (HAS_STACK) begin
                        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                        else begin
                            m_pc  = RST_ADDR;
                            m_err = 1'b1;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic idle_inputs();
        memReady        = 1'b0;
        memData         = '0;
        instrReady      = 1'b0;
        redirect        = 1'b0;
        redirectKind    = '0;
        redirectOperand = '0;
    endtask

    // Assumes the DUT is requesting; waits, then returns a byte
    task automatic fetch_one(input logic [DW-1:0] data, input int wait_cycles);
        total++;
        if (memReq !== 1'b1 || memAddr !== m_pc) begin
            bad++;
            $display("FAIL fetch_req: memReq=%b memAddr=%h, required 1/%h", memReq, memAddr, m_pc);
        end
        for (int i = 0; i < wait_cycles; i++) begin
            memReady        = 1'b0;
            memData         = 8'($urandom);
            instrReady      = 1'($urandom_range(0, 1));
            redirect        = 1'($urandom_range(0, 1));
            redirectKind    = 2'($urandom_range(0, 3));
            redirectOperand = 8'($urandom);
            tick();
            total++;
            if (memReq !== 1'b1 || instrValid !== 1'b0 || memAddr !== m_pc) begin
                bad++;
                $display("FAIL fetch_wait: memReq=%b instrValid=%b memAddr=%h, required 1/0/%h",
                         memReq, instrValid, memAddr, m_pc);
            end
        end
        redirect = 1'b0;
        memReady = 1'b1;
        memData  = data;
        tick();
        memReady     = 1'b0;
        memData      = 8'($urandom);
        instrReady   = 1'b0;
        m_held_pc    = m_pc;
        m_held_instr = data;
        m_pc         = m_pc + 8'd1;
        total++;
        if (instrValid !== 1'b1 || instr !== data || pcOut !== m_held_pc || memReq !== 1'b0) begin
            bad++;
            $display("FAIL fetch_done: valid=%b instr=%h pcOut=%h memReq=%b, required 1/%h/%h/0",
                     instrValid, instr, pcOut, memReq, data, m_held_pc);
        end
    endtask

    // Stalls the decoder (with ignored redirects/memReady), then accepts
    task automatic accept(input bit redir, input logic [1:0] kind, input logic [AW-1:0] op,
                          input int stall);
        for (int i = 0; i < stall; i++) begin
            instrReady      = 1'b0;
            redirect        = 1'($urandom_range(0, 1));
            redirectKind    = 2'($urandom_range(0, 3));
            redirectOperand = 8'($urandom);
            memReady        = 1'($urandom_range(0, 1));
            memData         = 8'($urandom);
            tick();
            total++;
            if (instrValid !== 1'b1 || instr !== m_held_instr || pcOut !== m_held_pc || memReq !== 1'b0) begin
                bad++;
                $display("FAIL hold_stall: valid=%b instr=%h pcOut=%h memReq=%b, required 1/%h/%h/0",
                         instrValid, instr, pcOut, memReq, m_held_instr, m_held_pc);
            end
        end
        memReady        = 1'b0;
        instrReady      = 1'b1;
        redirect        = redir;
        redirectKind    = kind;
        redirectOperand = op;
        tick();
        instrReady = 1'b0;
        redirect   = 1'b0;
        model_accept(redir, kind, op);
        total++;
        if (memReq !== 1'b1 || memAddr !== m_pc || instrValid !== 1'b0 || stackErr !== m_err) begin
            bad++;
            $display("FAIL accept: memReq=%b memAddr=%h valid=%b stackErr=%b, required 1/%h/0/%b",
                     memReq, memAddr, instrValid, stackErr, m_pc, m_err);
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        total++;
        if (memReq !== 1'b0 || memAddr !== RST_ADDR || instrValid !== 1'b0 ||
            instr !== 8'h00 || pcOut !== 8'h00 || stackErr !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: memReq=%b memAddr=%h valid=%b instr=%h pcOut=%h err=%b, required 0/%h/0/00/00/0",
                     memReq, memAddr, instrValid, instr, pcOut, stackErr, RST_ADDR);
        end
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        total++;
        if (memReq !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: memReq=%b, required 0", memReq);
        end
        tick();
        total++;
        if (memReq !== 1'b1 || memAddr !== RST_ADDR) begin
            bad++;
            $display("FAIL reset_first_req: memReq=%b memAddr=%h, required 1/%h", memReq, memAddr, RST_ADDR);
        end
    endtask

    task automatic test_sequential();
        logic [AW-1:0] exp_addr;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 8'(i);
            total++;
            if (memAddr !== exp_addr) begin
                bad++;
                $display("FAIL seq_addr: memAddr=%h, required %h", memAddr, exp_addr);
            end
            fetch_one(m_pc ^ 8'hA5, 0);
            accept(1'b0, K_JUMP, 8'h00, 0);
        end
    endtask

    task automatic test_wrap_backpressure();
        fetch_one(8'($urandom), 0);
        accept(1'b1, K_JUMP, 8'hFE, 0);
        fetch_one(8'h3C, 0);
        accept(1'b0, K_JUMP, 8'h00, 0);
        fetch_one(8'h5A, 1);
        accept(1'b0, K_JUMP, 8'h00, 5);
        total++;
        if (memAddr !== 8'h00) begin
            bad++;
            $display("FAIL wrap_addr: memAddr=%h, required 00", memAddr);
        end
    endtask

    task automatic test_branch_jump();
        fetch_one(8'($urandom), 0);
        accept(1'b1, K_JUMP, 8'h10, 0);
        fetch_one(8'h11, 0);
        accept(1'b1, K_BRANCH, 8'hFC, 3);
        total++;
        if (memAddr !== 8'h0D) begin
            bad++;
            $display("FAIL branch_back: memAddr=%h, required 0d", memAddr);
        end
        fetch_one(8'h22, 0);
        accept(1'b1, K_JUMP, 8'h40, 2);
        total++;
        if (memAddr !== 8'h40) begin
            bad++;
            $display("FAIL jump_abs: memAddr=%h, required 40", memAddr);
        end
        fetch_one(8'h33, 0);
        accept(1'b1, K_BRANCH, 8'h05, 0);
    endtask

    task automatic test_call_return();
        fetch_one(8'($urandom), 0);
        accept(1'b1, K_JUMP, 8'h05, 0);
        fetch_one(8'($urandom), 0);
        accept(1'b1, K_CALL, 8'h20, 0);
        fetch_one(8'($urandom), 0);
        accept(1'b1, K_CALL, 8'h50, 0);
        fetch_one(8'($urandom), 0);
        accept(1'b1, K_RET, 8'($urandom), 0);
        fetch_one(8'($urandom), 0);
        accept(1'b1, K_RET, 8'($urandom), 1);
        for (int i = 0; i < 5; i++) begin
            fetch_one(8'($urandom), 0);
            accept(1'b1, K_CALL, 8'(8'h60 + i), 0);
        end
        for (int i = 0; i < 5; i++) begin
            fetch_one(8'($urandom), 0);
            accept(1'b1, K_RET, 8'($urandom), 0);
        end
    endtask

    task automatic test_call_jump_no_stack();
        fetch_one(8'($urandom), 0);
        accept(1'b1, K_CALL, 8'h30, 0);
        total++;
        if (memAddr !== 8'h30) begin
            bad++;
            $display("FAIL call_target: memAddr=%h, required 30", memAddr);
        end
        fetch_one(8'($urandom), 0);
        accept(1'b1, K_RET, 8'h99, 0);
    endtask

    task automatic test_async_reset();
        // Reset in the middle of a fetch with memReady pending
        memReady = 1'b1;
        memData  = 8'h77;
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (memReq !== 1'b0 || instrValid !== 1'b0 || stackErr !== 1'b0 || memAddr !== RST_ADDR) begin
            bad++;
            $display("FAIL async_fetch: memReq=%b valid=%b err=%b memAddr=%h, required 0/0/0/%h",
                     memReq, instrValid, stackErr, memAddr, RST_ADDR);
        end
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        total++;
        if (memReq !== 1'b0 || instrValid !== 1'b0) begin
            bad++;
            $display("FAIL async_release: memReq=%b valid=%b, required 0/0", memReq, instrValid);
        end
        memReady = 1'b0;
        tick();
        total++;
        if (memReq !== 1'b1 || memAddr !== RST_ADDR || stackErr !== 1'b0) begin
            bad++;
            $display("FAIL async_first_req: memReq=%b memAddr=%h err=%b, required 1/%h/0",
                     memReq, memAddr, stackErr, RST_ADDR);
        end
        // Reset while holding an instruction
        fetch_one(8'hC3, 0);
        accept(1'b1, K_JUMP, 8'h80, 0);
        fetch_one(8'hD4, 0);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (instrValid !== 1'b0 || instr !== 8'h00 || pcOut !== 8'h00 || memAddr !== RST_ADDR) begin
            bad++;
            $display("FAIL async_hold: valid=%b instr=%h pcOut=%h memAddr=%h, required 0/00/00/%h",
                     instrValid, instr, pcOut, memAddr, RST_ADDR);
        end
        tick();
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_random();
        logic [1:0] kind;
        bit         redir;
        for (int n = 0; n < 150; n++) begin
            fetch_one(8'($urandom), int'($urandom_range(0, 2)));
            redir = ($urandom_range(0, 2) == 0);
            kind  = 2'($urandom_range(0, 3));
            accept(redir, kind, 8'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_wrap_backpressure();
        test_branch_jump();
        test_call_return();
        test_call_jump_no_stack();
        test_async_reset();
        test_random();
        apply_reset();
        test_call_jump_no_stack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Sequential program-counter and instruction-fetch front end for the 8-bit processor. Holds the PC register, issues fetch requests to instruction memory and holds each fetched byte until the decoder accepts it. Applies jump, relative branch, call and return redirects to the PC. It is the consumer of next-address arithmetic and the driver of the current address into the datapath.

## Interface
- ADDR_W, 8, PC and memory address width
- DATA_W, 8, instruction width
- RESET_ADDR, 8'h00, PC value after reset
- STACK_DEPTH, 4, return-stack entries (power of two)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- memAddr  out  ADDR_W  fetch address (= PC)
- memReq  out  1  fetch request
- memReady  in  1  memData valid this cycle
- memData  in  DATA_W  fetched instruction byte
- instr  out  DATA_W  held instruction
- instrValid  out  1  instr valid
- instrReady  in  1  decoder accepts instr
- pcOut  out  ADDR_W  address of held instr
- redirect  in  1  redirect request, qualified by accept
- redirectKind  in  2  00 jump, 01 branch, 10 call, 11 return
- redirectOperand  in  ADDR_W  absolute target (jump/call) or signed offset (branch)
- stackErr  out  1  sticky return-stack overflow/underflow flag

## Operation
- Reset values: PC=RESET_ADDR, state IDLE, memReq=0, memAddr=RESET_ADDR, instr=0, instrValid=0, pcOut=0, stackErr=0, stack empty.
- IDLE: one cycle, then FETCH unconditionally.
- FETCH: memReq=1, memAddr=PC. On memReady: instr<=memData, pcOut<=PC, PC<=PC+1 mod 2^ADDR_W (0xFF wraps to 0x00), go to HOLD.
- HOLD: instrValid=1, memReq=0, instr/pcOut stable. On instrValid&&instrReady (accept): go to FETCH, applying a redirect if one is present.
- Redirects are sampled only on the accept cycle. redirect in IDLE, in FETCH, or in HOLD without instrReady is ignored.
- jump: PC<=operand.
- branch: PC<=pcOut+1+sext(operand) mod 2^ADDR_W.
- call: push pcOut+1, PC<=operand. If the stack is full: no push, jump still taken, stackErr<=1.
- return: PC<=pop. If the stack is empty: PC<=RESET_ADDR, stackErr<=1.
- stackErr clears only on reset.

## Timing
- Reset deassert to first memReq: 1 cycle (IDLE), memReq high in the 2nd cycle.
- Zero-wait memory (memReady high in the first FETCH cycle): instrValid the next cycle. Peak throughput is one instruction per 2 cycles.
- memReady outside FETCH is ignored. memData is sampled only with memReady in FETCH.
- A redirected PC appears on memAddr in the cycle after accept.
- memReq/memAddr are derived from registered state only. There is no combinational path from memReady/instrReady to outputs.
- Asynchronous reset mid-fetch or mid-hold: all outputs return to their reset values immediately and the stack is emptied. An in-flight memReady is discarded.

## Configuration
- PC_RETURN_STACK_EN defined: call/return as above. The stack is instantiated and stackErr is live.
- PC_RETURN_STACK_EN undefined: call behaves as jump (no push). return is treated as no redirect (sequential PC). stackErr is tied 0 and no stack storage is generated.

## Structure
- Package pc_fetch_pkg: redirectKind encodings (KIND_JUMP, KIND_BRANCH, KIND_CALL, KIND_RETURN), state enum (IDLE, FETCH, HOLD), default RESET_ADDR.
- One sub-module: pc_return_stack. It is a LIFO of STACK_DEPTH×ADDR_W with push, pop, full, empty and a top output, plus asynchronous reset to empty. It is only instantiated under PC_RETURN_STACK_EN.

## Test plan
- Sequential fetch: reset, memReady always 1, instrReady always 1, memData=addr^8'hA5 → memAddr sequence 00,01,02 at 2-cycle spacing; pcOut/instr match each address.
- Wrap and backpressure: start at 0xFE, hold instrReady=0 for 5 cycles at 0xFF → instr/pcOut stable, memReq=0; after accept, memAddr=0x00.
- Branch/jump: accept at pcOut=0x10 with branch operand 8'hFC → next memAddr=0x0D; jump operand 0x40 → 0x40; redirect while instrReady=0 → ignored.
- Call/return nesting: calls from 0x05 and 0x20, then two returns → memAddr 0x21 then 0x06; a 5th nested call with depth 4 sets stackErr=1 with the jump still taken; return on empty → memAddr=RESET_ADDR, stackErr=1.
- Async reset asserted mid-FETCH with memReady pending → memReq=0 and instrValid=0 immediately; first memAddr after release is RESET_ADDR and stackErr=0.
- Build without PC_RETURN_STACK_EN: call 0x30 → memAddr 0x30; return → sequential PC; stackErr stays 0.
